// File: rtl/c_hazard_controller.sv
// Hazard controller: stall/flush/forward generation for the five-stage core
// and multi-cycle execute sequencing with a stall-cycle counter.
module c_hazard_controller #(
    parameter int MC_LATENCY = 4,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         Rs1D,
    input  logic [4:0]         Rs2D,
    input  logic [4:0]         Rs1E,
    input  logic [4:0]         Rs2E,
    input  logic [4:0]         RdE,
    input  logic [4:0]         RdM,
    input  logic [4:0]         RdW,
    input  logic               RegWE_W_E,
    input  logic               RegWE_M,
    input  logic               RegWE_W,
    input  logic               mc_op_E,
    input  logic               PCSrcE,
    input  logic               abort_E,
    output logic               StallF,
    output logic               StallD,
    output logic               StallE,
    output logic               FlushD,
    output logic               FlushE,
    output logic               FlushM,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic               mc_done_E,
    output logic [COUNT_W-1:0] stall_count
);

    localparam int CNT_W = $clog2(MC_LATENCY);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MC_LATENCY - 2);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             mc_stall;
    logic             mc_done;
    logic             branch;
    logic             load_use;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mc_stall = 1'b0;
        mc_done  = 1'b0;
        if (abort_E) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == IDLE) begin
            if (mc_op_E && !PCSrcE) begin
                mc_stall = 1'b1;
                state_nx = BUSY;
                cnt_nx   = CNT_START;
            end
        end else if (cnt != '0) begin
            mc_stall = 1'b1;
            cnt_nx   = cnt - 1'b1;
        end else begin
            // final EX cycle: the op retires at the next edge, so a still-high
            // mc_op_E is not seen again until the FSM is back in IDLE
            mc_done  = 1'b1;
            state_nx = IDLE;
        end
    end

    assign branch   = !abort_E && !mc_stall && PCSrcE;
    assign load_use = !abort_E && !mc_stall && !PCSrcE && RegWE_W_E
                      && (RdE != 5'd0)
                      && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (reset) begin
            unique case (1'b1)
                abort_E: begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                    FlushM = 1'b1;
                end
                mc_stall: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                end
                branch: begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end
                load_use: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mc_done_E = reset && mc_done;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWE_M && (RdM != 5'd0) && (RdM == rs))
            sel = 2'b10;
        else if (RegWE_W && (RdW != 5'd0) && (RdW == rs))
            sel = 2'b01;
        return sel;
    endfunction

    assign ForwardAE = reset ? fwd_sel(Rs1E) : 2'b00;
    assign ForwardBE = reset ? fwd_sel(Rs2E) : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (StallE && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_c_hazard_controller.sv
// Bench for c_hazard_controller: directed scenarios plus random traffic
// checked against a cycle-position reference model.
module tb_c_hazard_controller;

    localparam int L  = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWE_W_E, RegWE_M, RegWE_W, mc_op_E, PCSrcE, abort_E;
    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          mc_done_E;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state: position of the held op within EX (-1 = none)
    int pos    = -1;
    int scount = 0;
    int dones  = 0;

    logic [6:0] seen_ctl;
    logic [1:0] seen_fa;

    c_hazard_controller #(.MC_LATENCY(L), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWE_W_E(RegWE_W_E), .RegWE_M(RegWE_M), .RegWE_W(RegWE_W),
        .mc_op_E(mc_op_E), .PCSrcE(PCSrcE), .abort_E(abort_E),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mc_done_E(mc_done_E), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWE_M && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWE_W && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWE_W_E, RegWE_M, RegWE_W, mc_op_E, PCSrcE, abort_E} = '0;
    endtask

    task automatic rand_inputs();
        Rs1D = 5'($urandom_range(0, 3));
        Rs2D = 5'($urandom_range(0, 3));
        Rs1E = 5'($urandom_range(0, 3));
        Rs2E = 5'($urandom_range(0, 3));
        RdE  = 5'($urandom_range(0, 3));
        RdM  = 5'($urandom_range(0, 3));
        RdW  = 5'($urandom_range(0, 3));
        RegWE_W_E = 1'($urandom_range(0, 1));
        RegWE_M   = 1'($urandom_range(0, 1));
        RegWE_W   = 1'($urandom_range(0, 1));
        mc_op_E   = ($urandom_range(0, 9) < 4);
        PCSrcE    = ($urandom_range(0, 9) == 0);
        abort_E   = ($urandom_range(0, 39) == 0);
    endtask

    // one clock: check mid-cycle against the model, then advance at the edge
    task automatic cycle();
        int ep;
        bit ab, mcs, done, br, lu;
        logic [6:0] ectl;
        #4;
        ep = reset ? pos : -1;
        if (reset && ep < 0 && mc_op_E && !abort_E && !PCSrcE) ep = 0;
        ab   = reset && abort_E;
        mcs  = reset && !abort_E && ep >= 0 && ep <= L - 2;
        done = reset && !abort_E && ep == L - 1;
        br   = reset && !abort_E && !mcs && PCSrcE;
        lu   = reset && !abort_E && !mcs && !PCSrcE && RegWE_W_E
               && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        ectl = {mcs | lu, mcs | lu, mcs, ab | br, ab | br | lu, ab | mcs, done};
        seen_ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_done_E};
        seen_fa  = ForwardAE;
        if (mc_done_E === 1'b1) dones++;
        check("ctl", 32'(seen_ctl), 32'(ectl));
        check("fwdA", 32'(ForwardAE), reset ? 32'(ref_fwd(Rs1E)) : 32'd0);
        check("fwdB", 32'(ForwardBE), reset ? 32'(ref_fwd(Rs2E)) : 32'd0);
        check("stall_count", 32'(stall_count), reset ? 32'(scount) : 32'd0);
        @(posedge clk);
        if (!reset) begin
            pos    = -1;
            scount = 0;
        end else begin
            if (mcs && scount < (1 << CW) - 1) scount++;
            pos = (abort_E || ep < 0 || ep == L - 1) ? -1 : ep + 1;
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        rand_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_ctl", 32'(seen_ctl), 32'd0);
            rand_inputs();
        end
        check("rst_cnt", 32'(stall_count), 32'd0);

        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("idle_ctl", 32'(seen_ctl), 32'd0);
        end

        // multi-cycle op held in EX for L cycles
        mc_op_E = 1'b1;
        for (int i = 0; i < L - 1; i++) begin
            cycle();
            check("mc_stall", 32'(seen_ctl), 32'b1110010);
        end
        cycle();
        check("mc_done", 32'(seen_ctl), 32'b0000001);
        mc_op_E = 1'b0;
        check("mc_cnt", 32'(stall_count), 32'd3);
        cycle();
        check("mc_after", 32'(seen_ctl), 32'd0);

        // load-use
        RegWE_W_E = 1'b1; RdE = 5'd5; Rs2D = 5'd5;
        cycle();
        check("load_use", 32'(seen_ctl), 32'b1100100);
        RdE = 5'd0; Rs2D = 5'd0;
        cycle();
        check("load_x0", 32'(seen_ctl), 32'd0);

        // branch beats load-use
        RdE = 5'd5; Rs2D = 5'd5; PCSrcE = 1'b1;
        cycle();
        check("branch_lu", 32'(seen_ctl), 32'b0001100);
        clear_inputs();

        // forwarding priority
        RdM = 5'd7; RdW = 5'd7; RegWE_M = 1'b1; RegWE_W = 1'b1; Rs1E = 5'd7;
        cycle();
        check("fwd_mem", 32'(seen_fa), 32'd2);
        RegWE_M = 1'b0;
        cycle();
        check("fwd_wb", 32'(seen_fa), 32'd1);
        clear_inputs();

        // abort during the second BUSY cycle
        dones = 0;
        mc_op_E = 1'b1;
        cycle();
        check("ab_start", 32'(seen_ctl), 32'b1110010);
        abort_E = 1'b1;
        cycle();
        check("abort", 32'(seen_ctl), 32'b0001110);
        clear_inputs();
        for (int i = 0; i < L; i++) cycle();
        check("ab_nodone", 32'(dones), 32'd0);

        // reset pulsed mid-op
        mc_op_E = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        check("rst_mid_cnt", 32'(stall_count), 32'd0);
        mc_op_E = 1'b0;
        reset = 1'b1;
        cycle();
        check("rst_mid_idle", 32'(seen_ctl), 32'd0);

        // random traffic, long enough to saturate the counter
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            reset = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c_hazard_controller.md
# c_hazard_controller

Pipeline hazard controller for the five-stage core. It generates the stall and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers and the EX-stage forwarding selects. It also sequences multi-cycle execute operations by holding them in EX for a fixed latency. It sits beside the datapath, takes register addresses and control bits from ID, EX, MEM and WB, and drives StallF/StallD/StallE/FlushD/FlushE/FlushM.

## Interface

- MC_LATENCY, 4, cycles a multi-cycle op occupies EX (legal range 2..16)
- COUNT_W, 16, width of the stall-cycle performance counter
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source registers of the instruction in ID
- Rs1E, Rs2E, RdE  in  5  sources and destination of the instruction in EX
- RdM, RdW  in  5  destinations in MEM and WB
- RegWE_W_E  in  1  EX instruction writes its result at WB (load)
- RegWE_M, RegWE_W  in  1  register write enables in MEM and WB
- mc_op_E  in  1  EX instruction is a multi-cycle op
- PCSrcE  in  1  taken branch or jump resolved in EX
- abort_E  in  1  trap or abort request; kills ID and EX contents
- StallF, StallD, StallE  out  1  hold PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1  bubble IF/ID, ID/EX and EX/MEM registers
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 WB, 10 MEM
- mc_done_E  out  1  one-cycle pulse in the final EX cycle of a multi-cycle op
- stall_count  out  COUNT_W  saturating count of cycles with StallE=1

## Operation

- FSM states are IDLE and BUSY, with a down-counter cnt of width clog2(MC_LATENCY).
- IDLE, mc_op_E=1, abort_E=0, PCSrcE=0: assert mc stall, go to BUSY, cnt <= MC_LATENCY-2.
- BUSY, cnt!=0: assert mc stall, cnt <= cnt-1.
- BUSY, cnt==0: release the stall, pulse mc_done_E, go to IDLE. mc_op_E still high from the same op must not retrigger.
- Mc stall asserts StallF=StallD=StallE=1 and FlushM=1, so MEM receives bubbles while the op is held.
- Load-use: RegWE_W_E=1, RdE!=0 and (RdE==Rs1D or RdE==Rs2D), with no mc stall. Asserts StallF=StallD=1 and FlushE=1.
- Branch: PCSrcE=1 asserts FlushD=FlushE=1. It overrides load-use: no stalls that cycle.
- abort_E=1 has highest priority. It forces the FSM to IDLE, clears cnt, asserts FlushD=FlushE=FlushM=1 and all stalls 0, and suppresses mc_done_E.
- Forwarding for ForwardAE (ForwardBE is the same with Rs2E):
  - 10 when RegWE_M=1, RdM!=0 and RdM==Rs1E.
  - Otherwise 01 when RegWE_W=1, RdW!=0 and RdW==Rs1E.
  - Otherwise 00. MEM wins when both match.
- Register x0 never causes a hazard or a forward.
- stall_count increments every cycle StallE=1 and saturates at all-ones.

## Timing

- Stall, flush and forward outputs are combinational from inputs and FSM state, in the same cycle.
- FSM, cnt and stall_count update on the rising edge of clk.
- Reset (reset=0), asynchronous: state=IDLE, cnt=0, stall_count=0. All stall, flush and forward outputs and mc_done_E are 0 while reset is low.
- A multi-cycle op entering EX at cycle t stalls cycles t..t+MC_LATENCY-2. It pulses mc_done_E at t+MC_LATENCY-1 and leaves EX at the following edge.
- Back-to-back multi-cycle ops: the second enters EX right after the done cycle and starts from IDLE with no gap cycle.
- Reset or abort mid-op discards the op. The next cycle starts in IDLE.

## Test plan

- Reset with random inputs → all outputs 0 and stall_count=0. Release reset with no hazards → all outputs stay 0.
- MC_LATENCY=4, mc_op_E high from cycle 10 → StallE=1 in cycles 10–12, mc_done_E=1 in cycle 13, StallE=0 in cycle 13, stall_count=3.
- Load in EX with RdE=5 and Rs2D=5 → StallF=StallD=FlushE=1 for one cycle. Repeat with RdE=0 → no stall.
- PCSrcE=1 together with a load-use match → FlushD=FlushE=1 and StallF=StallD=0.
- RdM=RdW=7, both write enables set, Rs1E=7 → ForwardAE=10. Clear RegWE_M → 01.
- abort_E=1 at the second BUSY cycle → FSM returns to IDLE, Flush{D,E,M}=1 and mc_done_E never pulses. Repeat with reset pulsed mid-op → FSM IDLE and stall_count=0.
